// File: rtl/uart_pkg.sv
// uart_pkg: shared FSM encoding and line levels for the UART transmit scheduler.
// UART_TX_PARITY_EN adds the PARITY state to the encoding.
package uart_pkg;
  localparam logic LINE_IDLE = 1'b1;
  localparam logic LINE_START = 1'b0;
  localparam int DATA_W_DEF = 8;
`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {IDLE, WAIT_TICK, START, DATA, PARITY, STOP} tx_state_t;
`else
  typedef enum logic [2:0] {IDLE, WAIT_TICK, START, DATA, STOP} tx_state_t;
`endif
endpackage

// File: rtl/uart_rr_arbiter.sv
// uart_rr_arbiter: combinational round-robin pick of the first valid index at or after ptr.
module uart_rr_arbiter #(
  parameter int N = 4,
  localparam int IW = $clog2(N)
) (
  input  logic [N-1:0]  valid,
  input  logic [IW-1:0] ptr,
  output logic [IW-1:0] sel,
  output logic          any_valid
);
  logic [IW-1:0] idx;
  always_comb begin
    sel = '0;
    idx = '0;
    any_valid = |valid;
    // Scan farthest-first so the candidate nearest the pointer wins.
    for (int k = N - 1; k >= 0; k--) begin
      idx = IW'((int'(ptr) + k) % N);
      if (valid[idx]) sel = idx;
    end
  end
endmodule

// File: rtl/uart_tx_sched.sv
// uart_tx_sched: round-robin scheduler feeding one UART TX line, bit timing from TX_Clock edges.
// Define UART_TX_PARITY_EN to append an even-parity bit after the data bits.
module uart_tx_sched
  import uart_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int DATA_W = DATA_W_DEF,
  parameter int STOP_BITS = 1,
  localparam int IW = $clog2(NUM_REQ),
  localparam int CW = $clog2(DATA_W)
) (
  input  logic                      Clock,
  input  logic                      Reset_n,
  input  logic                      TX_Clock,
  input  logic [NUM_REQ-1:0]        Req_Valid,
  input  logic [NUM_REQ*DATA_W-1:0] Req_Data,
  output logic [NUM_REQ-1:0]        Req_Ready,
  output logic [IW-1:0]             Grant_Id,
  output logic                      TX,
  output logic                      Busy
);
  tx_state_t state, state_d;
  logic tx_clk_q, tick, any_valid, tx_d;
  logic [IW-1:0] ptr, ptr_d, sel, grant_d;
  logic [NUM_REQ-1:0] ready_d;
  logic [DATA_W-1:0] sh, sh_d;
  logic [CW-1:0] cnt, cnt_d;
`ifdef UART_TX_PARITY_EN
  logic par, par_d;
`endif

  assign tick = TX_Clock & ~tx_clk_q;
  assign Busy = state != IDLE;

  uart_rr_arbiter #(.N(NUM_REQ)) u_arb (
    .valid(Req_Valid),
    .ptr(ptr),
    .sel(sel),
    .any_valid(any_valid)
  );

  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      state <= IDLE;
      tx_clk_q <= 1'b0;
      ptr <= '0;
      sh <= '0;
      cnt <= '0;
      TX <= LINE_IDLE;
      Req_Ready <= '0;
      Grant_Id <= '0;
`ifdef UART_TX_PARITY_EN
      par <= 1'b0;
`endif
    end else begin
      state <= state_d;
      tx_clk_q <= TX_Clock;
      ptr <= ptr_d;
      sh <= sh_d;
      cnt <= cnt_d;
      TX <= tx_d;
      Req_Ready <= ready_d;
      Grant_Id <= grant_d;
`ifdef UART_TX_PARITY_EN
      par <= par_d;
`endif
    end
  end

  always_comb begin
    state_d = state;
    tx_d = TX;
    ready_d = '0;
    grant_d = Grant_Id;
    ptr_d = ptr;
    sh_d = sh;
    cnt_d = cnt;
`ifdef UART_TX_PARITY_EN
    par_d = par;
`endif
    case (state)
      IDLE: if (any_valid) begin
        ready_d = NUM_REQ'(1) << sel;
        sh_d = Req_Data[sel*DATA_W +: DATA_W];
`ifdef UART_TX_PARITY_EN
        par_d = ^Req_Data[sel*DATA_W +: DATA_W];
`endif
        grant_d = sel;
        ptr_d = (sel == IW'(NUM_REQ - 1)) ? '0 : sel + 1'b1;
        state_d = WAIT_TICK;
      end
      WAIT_TICK: if (tick) begin
        tx_d = LINE_START;
        state_d = START;
      end
      START: if (tick) begin
        tx_d = sh[0];
        sh_d = sh >> 1;
        cnt_d = '0;
        state_d = DATA;
      end
      DATA: if (tick) begin
        if (cnt == CW'(DATA_W - 1)) begin
`ifdef UART_TX_PARITY_EN
          tx_d = par;
          state_d = PARITY;
`else
          tx_d = LINE_IDLE;
          cnt_d = '0;
          state_d = STOP;
`endif
        end else begin
          tx_d = sh[0];
          sh_d = sh >> 1;
          cnt_d = cnt + 1'b1;
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: if (tick) begin
        tx_d = LINE_IDLE;
        cnt_d = '0;
        state_d = STOP;
      end
`endif
      STOP: if (tick) begin
        cnt_d = cnt + 1'b1;
        state_d = (cnt == CW'(STOP_BITS - 1)) ? IDLE : STOP;
      end
      default: state_d = IDLE;
    endcase
  end
endmodule

// File: tb/tb_uart_tx_sched.sv
// tb_uart_tx_sched: directed checks of arbitration, framing, tick alignment and async reset.
module tb_uart_tx_sched;
  logic Clock = 1'b0;
  logic Reset_n = 1'b0;
  logic TX_Clock = 1'b0;
  logic [3:0] Req_Valid = '0;
  logic [31:0] Req_Data = '0;
  logic [3:0] Req_Ready, ready2;
  logic [1:0] Grant_Id, grant2;
  logic TX, Busy, tx2, busy2;
  int checks = 0;
  int errors = 0;

  always #5 Clock = ~Clock;

  uart_tx_sched dut (
    .Clock(Clock), .Reset_n(Reset_n), .TX_Clock(TX_Clock), .Req_Valid(Req_Valid),
    .Req_Data(Req_Data), .Req_Ready(Req_Ready), .Grant_Id(Grant_Id), .TX(TX), .Busy(Busy)
  );

  uart_tx_sched #(.STOP_BITS(2)) dut2 (
    .Clock(Clock), .Reset_n(Reset_n), .TX_Clock(TX_Clock), .Req_Valid(Req_Valid),
    .Req_Data(Req_Data), .Req_Ready(ready2), .Grant_Id(grant2), .TX(tx2), .Busy(busy2)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge Clock);
    #1;
  endtask

  task automatic tick();
    cyc();
    cyc();
    TX_Clock = 1'b1;
    cyc();
    TX_Clock = 1'b0;
  endtask

  task automatic accept(input int id);
    cyc();
    chk("ready_onehot", 32'(Req_Ready), 32'(1) << id);
    chk("grant_id", 32'(Grant_Id), 32'(id));
    chk("busy_on_accept", 32'(Busy), 32'd1);
  endtask

  task automatic send_frame(input int id, input logic [7:0] b);
    cyc();
    chk("ready_one_cycle", 32'(Req_Ready), 32'd0);
    chk("idle_before_start", 32'(TX), 32'd1);
    tick();
    chk("start_bit", 32'(TX), 32'd0);
    for (int i = 0; i < 8; i++) begin
      tick();
      chk("data_bit", 32'(TX), 32'(b[i]));
    end
`ifdef UART_TX_PARITY_EN
    tick();
    chk("parity_bit", 32'(TX), 32'(^b));
`endif
    tick();
    chk("stop_bit", 32'(TX), 32'd1);
    chk("busy_in_stop", 32'(Busy), 32'd1);
    tick();
    chk("stop_end_tx", 32'(TX), 32'd1);
    chk("busy_falls", 32'(Busy), 32'd0);
    chk("grant_holds", 32'(Grant_Id), 32'(id));
  endtask

  initial begin
    #12;
    chk("rst_tx", 32'(TX), 32'd1);
    chk("rst_busy", 32'(Busy), 32'd0);
    chk("rst_ready", 32'(Req_Ready), 32'd0);
    chk("rst_grant", 32'(Grant_Id), 32'd0);
    #5 Reset_n = 1'b1;
    cyc();
    // single byte A5 from requester 0; the 2-stop-bit instance runs alongside
    Req_Data[7:0] = 8'hA5;
    Req_Valid = 4'b0001;
    accept(0);
    Req_Valid = '0;
    send_frame(0, 8'hA5);
    chk("stop2_busy", 32'(busy2), 32'd1);
    chk("stop2_tx", 32'(tx2), 32'd1);
    tick();
    chk("stop2_busy_falls", 32'(busy2), 32'd0);
    chk("stop2_tx_end", 32'(tx2), 32'd1);
    // reset while data bit 3 (a zero) is on the line
    Req_Data[23:16] = 8'h35;
    Req_Valid = 4'b0100;
    accept(2);
    Req_Valid = '0;
    repeat (5) tick();
    chk("bit3_low", 32'(TX), 32'd0);
    #2 Reset_n = 1'b0;
    #1;
    chk("async_rst_tx", 32'(TX), 32'd1);
    chk("async_rst_busy", 32'(Busy), 32'd0);
    chk("async_rst_ready", 32'(Req_Ready), 32'd0);
    chk("async_rst_grant", 32'(Grant_Id), 32'd0);
    #3 Reset_n = 1'b1;
    tick();
    tick();
    chk("post_rst_idle_tx", 32'(TX), 32'd1);
    chk("post_rst_idle_busy", 32'(Busy), 32'd0);
    // round robin with all requesters valid, back-to-back frames
    Req_Data = {8'h13, 8'h12, 8'h11, 8'h10};
    Req_Valid = 4'hF;
    for (int g = 0; g < 5; g++) begin
      accept(g % 4);
      send_frame(g % 4, 8'(8'h10 + g % 4));
    end
    Req_Valid = '0;
    // pointer skip: grant 1, then 3 ahead of 0
    Req_Valid = 4'b0010;
    accept(1);
    Req_Valid = '0;
    send_frame(1, 8'h11);
    Req_Valid = 4'b1001;
    accept(3);
    Req_Valid = 4'b0001;
    send_frame(3, 8'h13);
    accept(0);
    Req_Valid = '0;
    send_frame(0, 8'h10);
    // tick coinciding with the selection cycle must not start the frame
    Req_Data[7:0] = 8'h5A;
    Req_Valid = 4'b0001;
    TX_Clock = 1'b1;
    accept(0);
    TX_Clock = 1'b0;
    Req_Valid = '0;
    chk("no_start_on_accept_tick", 32'(TX), 32'd1);
    send_frame(0, 8'h5A);
`ifdef UART_TX_PARITY_EN
    Req_Data[23:16] = 8'h07;
    Req_Valid = 4'b0100;
    accept(2);
    Req_Valid = '0;
    send_frame(2, 8'h07);
    Req_Data[23:16] = 8'h03;
    Req_Valid = 4'b0100;
    accept(2);
    Req_Valid = '0;
    send_frame(2, 8'h03);
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/uart_tx_sched.md
Name: uart_tx_sched

Overview:
- Round-robin scheduler that shares one UART serial transmit line between NUM_REQ requesters.
- Takes the baud generator's TX_Clock output and turns each of its rising edges into a one-Clock bit tick.
- Accepts one byte per handshake from the granted requester and serialises it as a start / data / stop frame, LSB first.
- Sits between the baud generator and the per-source message logic.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- DATA_W, 8, data bits per frame.
- STOP_BITS, 1, stop bits per frame (1 or 2).

Ports:
- Clock  in  1  system clock; also samples TX_Clock.
- Reset_n  in  1  asynchronous, active-low reset.
- TX_Clock  in  1  bit-rate clock from the baud generator, synchronous to Clock; its rising edge is the bit tick.
- Req_Valid  in  NUM_REQ  per-requester byte-available flag.
- Req_Data  in  NUM_REQ*DATA_W  packed bytes; requester i occupies bits [i*DATA_W +: DATA_W].
- Req_Ready  out  NUM_REQ  one-hot, one-cycle accept pulse.
- Grant_Id  out  clog2(NUM_REQ)  index of the requester whose frame is in flight.
- TX  out  1  serial line, idle high.
- Busy  out  1  high from accept until the end of the last stop bit.

Behaviour:
- Bit tick generation:
  - Register tx_clk_q <= TX_Clock.
  - tick = TX_Clock & ~tx_clk_q, one Clock wide.
- Reset (asynchronous, Reset_n low):
  - State = IDLE, TX=1, Busy=0, Req_Ready=0, Grant_Id=0.
  - Round-robin pointer = 0, so requester 0 has highest priority first.
  - Shift register and counters cleared; tx_clk_q=0.
- Reset asserted mid-frame: TX returns to 1 immediately. The frame is abandoned and never resent; the requester already saw Ready.
- FSM states: IDLE, WAIT_TICK, START, DATA, [PARITY], STOP.
- IDLE, any Req_Valid high:
  - Select the first valid index at or after the pointer, wrapping modulo NUM_REQ.
  - Next cycle (registered):
    - Req_Ready[sel]=1 for exactly one cycle.
    - Latch Req_Data[sel] into the shift register.
    - Grant_Id=sel, Busy=1.
    - Pointer = sel+1 mod NUM_REQ.
    - Go to WAIT_TICK.
- WAIT_TICK: on tick, TX=0 and go to START. Aligns the start bit to a bit boundary; latency accept→start edge is 1..one bit period.
- START: on tick, TX=data[0] and go to DATA.
- DATA:
  - Each tick shifts the next bit out; counter runs 0..DATA_W-1.
  - On the tick after the last data bit, TX=1 and go to STOP (or to PARITY if enabled).
- STOP: holds TX=1 for STOP_BITS ticks. On the final tick, Busy=0 and go to IDLE.
  - A new accept can occur the cycle after IDLE is re-entered.
  - The next start bit therefore follows on the next tick, giving back-to-back frames with no extra idle bit.
- Requester contract:
  - Req_Valid and Req_Data must be held until Req_Ready.
  - Dropping Valid before Ready is legal; the requester is simply skipped.
  - Valid seen only in non-IDLE states is ignored until IDLE.
- Simultaneous events:
  - A tick in the same cycle as an accept is not used; WAIT_TICK waits for the next tick.
  - Valid deasserting in the cycle of selection: the selection uses that cycle's value.
- Grant_Id holds its value after Busy falls until the next accept.

Optional Feature:
- Macro: UART_TX_PARITY_EN.
- Defined:
  - PARITY state between DATA and STOP sends even parity (XOR of the data bits) for one tick.
  - Frame = 1 start + DATA_W data + 1 parity + STOP_BITS stop.
- Undefined: no PARITY state or logic; frame = 1 start + DATA_W data + STOP_BITS stop.

Decomposition:
- Shared package uart_pkg:
  - State encoding typedef for tx_state_t.
  - Constants for line idle level (1), start level (0), and default DATA_W.
- One sub-module, uart_rr_arbiter: combinational round-robin selection from Req_Valid and the pointer, returning sel index and any_valid.
- Pointer register, tick detection and FSM live in uart_tx_sched.

Test Plan:
- Reset mid-frame: Reset_n low during DATA bit 3 → TX=1, Busy=0, Req_Ready=0, Grant_Id=0 asynchronously; after release, line idles high until next Valid.
- Single byte: Req_Valid[0]=1, data 8'hA5 → Req_Ready=4'b0001 for one cycle; TX per tick = 0,1,0,1,0,0,1,0,1,1; Busy falls on the final stop tick.
- Round-robin: all four Valid held with distinct bytes 8'h10..8'h13 → Grant_Id sequence 0,1,2,3,0; frames back-to-back with no extra idle tick.
- Pointer skip: after grant to 1, only Req_Valid[0] and [3] high → requester 3 granted before 0.
- Tick alignment: accept one cycle before a tick → the start bit begins on the following tick, never the same-cycle tick; STOP_BITS=2 → TX high for two ticks.
- Parity (UART_TX_PARITY_EN): byte 8'h07 → parity bit 1 before the stop bit; byte 8'h03 → parity bit 0.
